// File: rtl/lsu_ctrl_if.sv
// Handshake bundles for the load/store controller: core side (request/response)
// and data-memory side (bus request/response).
interface lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_memop, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_wen, req_memop, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
  modport slave (
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding access, byte-lane alignment, sign/zero
// extension, and error reporting for misalignment, illegal ops and bus timeouts.
module lsu_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst,
  lsu_core_if.slave core,
  lsu_mem_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       memop_q, memop_d;
  logic [1:0]       off_q, off_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  logic             mem_wen_q, mem_wen_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             req_ready;

  function automatic logic req_illegal(input logic wen, input logic [2:0] op,
                                       input logic [1:0] off);
    case (op)
      OP_B:    req_illegal = 1'b0;
      OP_H:    req_illegal = off[0];
      OP_W:    req_illegal = (off != 2'b00);
      OP_BU:   req_illegal = wen;
      OP_HU:   req_illegal = wen | off[0];
      default: req_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_B:    store_strb = 4'b0001 << off;
      OP_H:    store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_B:    store_data = {4{wd[7:0]}};
      OP_H:    store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (op)
      OP_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      OP_BU:   load_extend = {24'h0, sh[7:0]};
      OP_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      OP_HU:   load_extend = {16'h0, sh[15:0]};
      default: load_extend = rd;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    memop_d         = memop_q;
    off_d           = off_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_wen_d       = mem_wen_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    resp_valid_d    = resp_valid_q;
    resp_err_d      = resp_err_q;
    resp_rdata_d    = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (core.req_valid && req_ready) begin
          memop_d = core.req_memop;
          off_d   = core.req_addr[1:0];
          if (req_illegal(core.req_wen, core.req_memop, core.req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d         = REQ;
            cnt_d           = '0;
            mem_req_valid_d = 1'b1;
            mem_wen_d       = core.req_wen;
            mem_addr_d      = {core.req_addr[31:2], 2'b00};
            mem_wdata_d     = core.req_wen ? store_data(core.req_memop, core.req_wdata) : 32'h0;
            mem_wstrb_d     = core.req_wen ? store_strb(core.req_memop, core.req_addr[1:0]) : 4'b0000;
          end
        end
      end
      REQ: begin
        // The exit event wins over a timeout landing in the same cycle.
        if (mem.mem_req_ready) begin
          state_d         = WAIT;
          mem_req_valid_d = 1'b0;
          cnt_d           = cnt_q + 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = RESP;
          mem_req_valid_d = 1'b0;
          resp_valid_d    = 1'b1;
          resp_err_d      = 1'b1;
          resp_rdata_d    = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_wen_q ? 32'h0 : load_extend(memop_q, off_q, mem.mem_rsp_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (core.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      memop_q         <= 3'b000;
      off_q           <= 2'b00;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_wdata_q     <= 32'h0;
      mem_wstrb_q     <= 4'b0000;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= 32'h0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      memop_q         <= memop_d;
      off_q           <= off_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_wen_q       <= mem_wen_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

  assign core.req_ready  = req_ready;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem.mem_req_valid = mem_req_valid_q;
  assign mem.mem_wen       = mem_wen_q;
  assign mem.mem_addr      = mem_addr_q;
  assign mem.mem_wdata     = mem_wdata_q;
  assign mem.mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected bus requests and
// core responses; negedge monitors pop and compare on every handshake.
module tb_lsu_ctrl;
  localparam int TO = 8;
  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_core_if core ();
  lsu_mem_if  mem ();

  lsu_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core),
    .mem  (mem)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        chk_wd;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  logic       e_wen [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0] e_op  [6] = '{OP_W, 3'b011, OP_BU, OP_H, OP_H, 3'b111};
  logic [31:0] e_adr[6] = '{32'h3002, 32'h3000, 32'h3000, 32'h3001, 32'h3003, 32'h3004};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Response and bus-request monitors
  always @(negedge clk) begin
    resp_t r;
    mreq_t m;
    if (!rst && core.resp_valid && core.resp_ready) begin
      if (resp_q.size() == 0) flag("resp_unexpected");
      else begin
        r = resp_q.pop_front();
        check("resp_rdata", core.resp_rdata, r.rdata);
        check("resp_err", {31'h0, core.resp_err}, {31'h0, r.err});
      end
    end
    if (!rst && mem.mem_req_valid && mem.mem_req_ready) begin
      if (mreq_q.size() == 0) flag("mem_req_unexpected");
      else begin
        m = mreq_q.pop_front();
        check("mem_addr", mem.mem_addr, m.addr);
        check("mem_wen", {31'h0, mem.mem_wen}, {31'h0, m.wen});
        check("mem_wstrb", {28'h0, mem.mem_wstrb}, {28'h0, m.strb});
        if (m.chk_wd) check("mem_wdata", mem.mem_wdata, m.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_resp(input logic [31:0] rd, input logic err);
    resp_t r;
    r.rdata = rd;
    r.err   = err;
    resp_q.push_back(r);
  endtask

  task automatic exp_mem(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] s, input logic chk);
    mreq_t m;
    m.addr = a; m.wen = w; m.wdata = wd; m.strb = s; m.chk_wd = chk;
    mreq_q.push_back(m);
  endtask

  // Returns one cycle after the request handshake edge (cycle 1).
  task automatic send(input logic w, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] wd);
    int n = 0;
    core.req_valid = 1'b1;
    core.req_wen   = w;
    core.req_memop = op;
    core.req_addr  = a;
    core.req_wdata = wd;
    while (!core.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!core.req_ready) flag("req_ready_never_high");
    tick();
    core.req_valid = 1'b0;
  endtask

  task automatic mem_serve(input int rdy_dly, input int rsp_dly, input logic [31:0] rd);
    repeat (rdy_dly) tick();
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    repeat (rsp_dly) tick();
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_rdata = rd;
    tick();
    mem.mem_rsp_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    while (!core.resp_valid && n < 3 * TO) begin
      tick();
      n++;
    end
    if (!core.resp_valid) flag(name);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    core.req_valid = 1'b0; core.req_wen = 1'b0; core.req_memop = 3'b000;
    core.req_addr = 32'h0; core.req_wdata = 32'h0; core.resp_ready = 1'b1;
    mem.mem_req_ready = 1'b0; mem.mem_rsp_valid = 1'b0; mem.mem_rsp_rdata = 32'h0;
    tick();
    tick();
    check("rst_req_ready", {31'h0, core.req_ready}, 32'h0);
    check("rst_resp_valid", {31'h0, core.resp_valid}, 32'h0);
    check("rst_mem_req_valid", {31'h0, mem.mem_req_valid}, 32'h0);
    check("rst_mem_wstrb", {28'h0, mem.mem_wstrb}, 32'h0);
    check("rst_mem_addr", mem.mem_addr, 32'h0);
    check("rst_resp_rdata", core.resp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", {31'h0, core.req_ready}, 32'h1);
    tick();

    // LB at minimum latency
    exp_mem(32'h1000, 1'b0, 32'h0, 4'b0000, 1'b0);
    exp_resp(32'hFFFF_FF80, 1'b0);
    send(1'b0, OP_B, 32'h1003, 32'h0);
    check("lat_c1_mem_req_valid", {31'h0, mem.mem_req_valid}, 32'h1);
    check("lat_c1_req_ready", {31'h0, core.req_ready}, 32'h0);
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_rdata = 32'h80FF_1234;
    tick();
    mem.mem_rsp_valid = 1'b0;
    check("lat_c3_resp_valid", {31'h0, core.resp_valid}, 32'h1);
    tick();

    // LBU, SH, SB, SW, LHU, positive LB
    exp_mem(32'h1000, 1'b0, 32'h0, 4'b0000, 1'b0);
    exp_resp(32'h0000_0080, 1'b0);
    send(1'b0, OP_BU, 32'h1003, 32'h0);
    mem_serve(0, 0, 32'h80FF_1234);
    wait_resp("lbu_no_resp");
    tick();

    exp_mem(32'h2000, 1'b1, 32'hABCD_ABCD, 4'b1100, 1'b1);
    exp_resp(32'h0, 1'b0);
    send(1'b1, OP_H, 32'h2002, 32'h0000_ABCD);
    mem_serve(0, 0, 32'h1234_5678);
    wait_resp("sh_no_resp");
    tick();

    exp_mem(32'h6000, 1'b1, 32'h5A5A_5A5A, 4'b0010, 1'b1);
    exp_resp(32'h0, 1'b0);
    send(1'b1, OP_B, 32'h6001, 32'h1234_565A);
    mem_serve(1, 1, 32'hFFFF_FFFF);
    wait_resp("sb_no_resp");
    tick();

    exp_mem(32'h9000, 1'b1, 32'hCAFE_F00D, 4'b1111, 1'b1);
    exp_resp(32'h0, 1'b0);
    send(1'b1, OP_W, 32'h9000, 32'hCAFE_F00D);
    mem_serve(0, 2, 32'h0);
    wait_resp("sw_no_resp");
    tick();

    exp_mem(32'h8000, 1'b0, 32'h0, 4'b0000, 1'b0);
    exp_resp(32'h0000_8001, 1'b0);
    send(1'b0, OP_HU, 32'h8002, 32'h0);
    mem_serve(0, 0, 32'h8001_0000);
    wait_resp("lhu_no_resp");
    tick();

    exp_mem(32'h9000, 1'b0, 32'h0, 4'b0000, 1'b0);
    exp_resp(32'h0000_007F, 1'b0);
    send(1'b0, OP_B, 32'h9001, 32'h0);
    mem_serve(0, 0, 32'h0000_7F00);
    wait_resp("lb_pos_no_resp");
    tick();

    // Request-side errors: response at cycle 1, no bus activity
    for (int i = 0; i < 6; i++) begin
      exp_resp(32'h0, 1'b1);
      send(e_wen[i], e_op[i], e_adr[i], 32'hFFFF_FFFF);
      check("err_c1_resp_valid", {31'h0, core.resp_valid}, 32'h1);
      check("err_c1_mem_req_valid", {31'h0, mem.mem_req_valid}, 32'h0);
      tick();
      check("err_c2_mem_req_valid", {31'h0, mem.mem_req_valid}, 32'h0);
    end

    // Timeout in WAIT, then a stale response pulse
    exp_mem(32'h5000, 1'b0, 32'h0, 4'b0000, 1'b0);
    exp_resp(32'h0, 1'b1);
    send(1'b0, OP_W, 32'h5000, 32'h0);
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    k = 2;
    while (!core.resp_valid && k < 30) begin
      tick();
      k++;
    end
    check("timeout_wait_cycle", k, 9);
    tick();
    tick();
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_rdata = 32'h1111_2222;
    tick();
    mem.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_resp_valid", {31'h0, core.resp_valid}, 32'h0);
      tick();
    end
    check("stale_req_ready", {31'h0, core.req_ready}, 32'h1);

    // Timeout in REQ: bus never accepts
    exp_resp(32'h0, 1'b1);
    send(1'b0, OP_W, 32'h5100, 32'h0);
    k = 1;
    while (!core.resp_valid && k < 30) begin
      tick();
      k++;
    end
    check("timeout_req_cycle", k, 9);
    check("timeout_req_mem_valid", {31'h0, mem.mem_req_valid}, 32'h0);
    tick();

    // Stalled bus acceptance and stalled response consumption
    core.resp_ready = 1'b0;
    exp_mem(32'h6000, 1'b0, 32'h0, 4'b0000, 1'b0);
    exp_resp(32'hFFFF_F00D, 1'b0);
    send(1'b0, OP_H, 32'h6002, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall_mem_valid", {31'h0, mem.mem_req_valid}, 32'h1);
      check("stall_mem_addr", mem.mem_addr, 32'h6000);
      check("stall_mem_wen", {31'h0, mem.mem_wen}, 32'h0);
      check("stall_mem_wstrb", {28'h0, mem.mem_wstrb}, 32'h0);
      tick();
    end
    mem_serve(0, 0, 32'hF00D_0000);
    wait_resp("stall_no_resp");
    for (int i = 0; i < 4; i++) begin
      check("stall_resp_valid", {31'h0, core.resp_valid}, 32'h1);
      check("stall_resp_rdata", core.resp_rdata, 32'hFFFF_F00D);
      check("stall_resp_err", {31'h0, core.resp_err}, 32'h0);
      check("stall_req_ready", {31'h0, core.req_ready}, 32'h0);
      tick();
    end
    core.resp_ready = 1'b1;
    #1;
    check("stall_hs_req_ready", {31'h0, core.req_ready}, 32'h0);
    tick();
    check("after_hs_req_ready", {31'h0, core.req_ready}, 32'h1);
    check("after_hs_resp_valid", {31'h0, core.resp_valid}, 32'h0);

    // Reset while in WAIT aborts silently
    exp_mem(32'h7000, 1'b0, 32'h0, 4'b0000, 1'b0);
    send(1'b0, OP_W, 32'h7000, 32'h0);
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    check("abort_rst_resp_valid", {31'h0, core.resp_valid}, 32'h0);
    check("abort_rst_mem_addr", mem.mem_addr, 32'h0);
    check("abort_rst_req_ready", {31'h0, core.req_ready}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_rel_req_ready", {31'h0, core.req_ready}, 32'h1);
    check("abort_rel_mem_valid", {31'h0, mem.mem_req_valid}, 32'h0);
    check("abort_rel_resp_rdata", core.resp_rdata, 32'h0);
    tick();
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_rdata = 32'h5555_5555;
    tick();
    mem.mem_rsp_valid = 1'b0;
    check("abort_stale_resp_valid", {31'h0, core.resp_valid}, 32'h0);
    tick();
    check("abort_stale_resp_valid2", {31'h0, core.resp_valid}, 32'h0);

    exp_mem(32'h4000, 1'b0, 32'h0, 4'b0000, 1'b0);
    exp_resp(32'hDEAD_BEEF, 1'b0);
    send(1'b0, OP_W, 32'h4000, 32'h0);
    mem_serve(0, 0, 32'hDEAD_BEEF);
    wait_resp("post_rst_no_resp");
    tick();
    tick();

    check("sb_resp_drained", resp_q.size(), 0);
    check("sb_mem_drained", mreq_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
